// File: rtl/vote_machine_pkg.sv
// Shared types and constants for the four-candidate ballot counter.
package vote_pkg;
  localparam int CNT_W = 12;
  localparam int NCAND = 4;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {OFF, IDLE, ARMED, CLOSED} state_t;

  localparam logic [2:0] IDX_C1  = 3'd0;
  localparam logic [2:0] IDX_C2  = 3'd1;
  localparam logic [2:0] IDX_C3  = 3'd2;
  localparam logic [2:0] IDX_C4  = 3'd3;
  localparam logic [2:0] IDX_INV = 3'd4;
  localparam logic [2:0] IDX_TOT = 3'd5;
  localparam logic [2:0] IDX_WIN = 3'd6;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == {CNT_W{1'b1}}) ? v : v + cnt_t'(1);
  endfunction
endpackage

// File: rtl/vote_machine_if.sv
// Operator/voter console bundle between the panel and the counter.
interface vote_machine_if;
  import vote_pkg::*;
  logic       Power;
  logic       Close;
  logic       Ballot;
  logic       Total;
  logic       Result;
  logic [3:0] IN;
  cnt_t       out;

  modport master (output Power, Close, Ballot, Total, Result, IN, input out);
  modport slave  (input Power, Close, Ballot, Total, Result, IN, output out);
endinterface

// File: rtl/vote_machine_rise_detect.sv
// One-cycle rising-edge pulse from a level input.
module rise_detect (
  input  logic clk,
  input  logic clr,
  input  logic sig,
  output logic rise
);
  logic sig_q;

  always_ff @(posedge clk) begin
    if (clr) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
endmodule

// File: rtl/vote_machine.sv
// Ballot counter: one vote per Ballot pulse, results stepped on a 12-bit display.
module vote_machine
  import vote_pkg::*;
(
  input logic           clk,
  input logic           Clear,
  vote_machine_if.slave bus
);
  localparam int NEV = 4;

  logic [NEV-1:0] lvl, ev;
  logic ev_ballot, ev_total, ev_close, ev_result;

  assign lvl = {bus.Result, bus.Close, bus.Total, bus.Ballot};

  genvar g;
  generate
    for (g = 0; g < NEV; g++) begin : g_rise
      rise_detect u_rise (.clk(clk), .clr(Clear), .sig(lvl[g]), .rise(ev[g]));
    end
  endgenerate

  assign ev_ballot = ev[0];
  assign ev_total  = ev[1];
  assign ev_close  = ev[2];
  assign ev_result = ev[3];

  state_t                      state;
  logic [NCAND-1:0][CNT_W-1:0] cand;
  cnt_t                        inv, tot, out_r;
  logic [2:0]                  idx, idx_nxt;
  logic [2:0]                  win;
  cnt_t                        disp;

  assign bus.out = out_r;

  // Winner needs a unique maximum; any tie at the top (all-zero too) reports 0.
  always_comb begin
    cnt_t       max_v;
    logic [2:0] n_max;
    max_v = '0;
    n_max = '0;
    win   = '0;
    for (int k = 0; k < NCAND; k++) begin
      if (cand[k] > max_v) begin
        max_v = cand[k];
        n_max = 3'd1;
        win   = 3'(k + 1);
      end else if (cand[k] == max_v) begin
        n_max = n_max + 3'd1;
      end
    end
    if (n_max != 3'd1) win = '0;
  end

  assign idx_nxt = (idx == IDX_WIN) ? IDX_C1 : idx + 3'd1;

  always_comb begin
    disp = '0;
    case (idx_nxt)
      IDX_C1:  disp = cand[0];
      IDX_C2:  disp = cand[1];
      IDX_C3:  disp = cand[2];
      IDX_C4:  disp = cand[3];
      IDX_INV: disp = inv;
      IDX_TOT: disp = tot;
      IDX_WIN: disp = CNT_W'(win);
      default: disp = '0;
    endcase
  end

  // Priority: Clear > Power-low > Close > Total > Ballot/IN. An unknown Power
  // falls through the if-tests to OFF.
  always_ff @(posedge clk) begin
    if (Clear) begin
      cand  <= '0;
      inv   <= '0;
      tot   <= '0;
      idx   <= IDX_C1;
      out_r <= '0;
      if (bus.Power) state <= IDLE;
      else           state <= OFF;
    end else if (bus.Power) begin
      case (state)
        OFF: state <= IDLE;
        IDLE, ARMED: begin
          if (ev_close) begin
            state <= CLOSED;
            idx   <= IDX_C1;
            out_r <= cand[0];
          end else if (ev_total) begin
            out_r <= tot;
          end else if (state == IDLE) begin
            if (ev_ballot) state <= ARMED;
          end else if (bus.IN != 4'd0) begin
            if (is_onehot4(bus.IN)) begin
              for (int k = 0; k < NCAND; k++)
                if (bus.IN[k]) cand[k] <= sat_inc(cand[k]);
            end else begin
              inv <= sat_inc(inv);
            end
            tot   <= sat_inc(tot);
            state <= IDLE;
          end
        end
        CLOSED: begin
          if (ev_result) begin
            idx   <= idx_nxt;
            out_r <= disp;
          end
        end
        default: state <= OFF;
      endcase
    end else begin
      state <= OFF;
      out_r <= '0;
    end
  end
endmodule

// File: tb/tb_vote_machine.sv
// Directed + randomized bench for vote_machine against a tally-array model.
module tb_vote_machine;
  logic clk = 1'b0;
  logic Clear;
  always #5 clk = ~clk;

  vote_machine_if vif ();
  vote_machine dut (.clk(clk), .Clear(Clear), .bus(vif));

  int vectors = 0;
  int miscompares = 0;

  // Reference tallies: plain integers, saturation applied arithmetically.
  int m_c[4];
  int m_inv, m_tot;

  function automatic int sat(input int v);
    return (v >= 4095) ? 4095 : v + 1;
  endfunction

  function automatic int winner();
    int best, n, w;
    best = -1; n = 0; w = 0;
    for (int k = 0; k < 4; k++) begin
      if (m_c[k] > best) begin best = m_c[k]; n = 1; w = k + 1; end
      else if (m_c[k] == best) n++;
    end
    return (n == 1) ? w : 0;
  endfunction

  function automatic int expect_idx(input int i);
    case (i)
      0, 1, 2, 3: return m_c[i];
      4: return m_inv;
      5: return m_tot;
      default: return winner();
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input int exp_v);
    logic [11:0] e;
    e = 12'(exp_v);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) m_c[k] = 0;
    m_inv = 0; m_tot = 0;
  endtask

  task automatic model_vote(input logic [3:0] sel);
    if ($countones(sel) == 1) begin
      for (int k = 0; k < 4; k++) if (sel[k]) m_c[k] = sat(m_c[k]);
    end else begin
      m_inv = sat(m_inv);
    end
    m_tot = sat(m_tot);
  endtask

  task automatic do_clear();
    Clear = 1'b1; step();
    check("clear_out", vif.out, 0);
    Clear = 1'b0;
    model_clear();
  endtask

  // Arm, then present sel for 'hold' edges; only the first edge counts.
  task automatic vote(input logic [3:0] sel, input int hold);
    vif.Ballot = 1'b1; step();
    vif.Ballot = 1'b0; vif.IN = sel;
    repeat (hold) step();
    vif.IN = 4'd0;
    model_vote(sel);
  endtask

  task automatic show_total(input string tag);
    vif.Total = 1'b1; step();
    check(tag, vif.out, m_tot);
    vif.Total = 1'b0; step();
  endtask

  // Close, then walk all seven display slots plus one wrap back to c1.
  task automatic read_all(input string tag);
    int i;
    vif.Close = 1'b1; step();
    i = 0;
    check({tag, "_close_c1"}, vif.out, m_c[0]);
    vif.Close = 1'b0; step();
    for (int r = 0; r < 8; r++) begin
      vif.Result = 1'b1; step();
      i = (i + 1) % 7;
      check($sformatf("%s_idx%0d", tag, i), vif.out, expect_idx(i));
      vif.Result = 1'b0; step();
    end
  endtask

  initial begin
    logic [3:0] pats[4];
    logic [3:0] sel;
    pats[0] = 4'b0101; pats[1] = 4'b1001; pats[2] = 4'b1111; pats[3] = 4'b1100;
    Clear = 1'b1;
    vif.Power = 1'b0; vif.Close = 1'b0; vif.Ballot = 1'b0;
    vif.Total = 1'b0; vif.Result = 1'b0; vif.IN = 4'd0;
    model_clear();
    step();
    check("reset_out", vif.out, 0);
    Clear = 1'b0;

    // Powered off: a ballot attempt must leave no trace.
    vif.Ballot = 1'b1; step();
    vif.Ballot = 1'b0; vif.IN = 4'b0001; step();
    vif.IN = 4'd0; step();
    check("off_out", vif.out, 0);
    vif.Power = 1'b1; step();
    show_total("off_ignored_tot");
    read_all("empty");

    // Second selection in the same ballot is ignored.
    do_clear();
    vif.Ballot = 1'b1; step();
    vif.Ballot = 1'b0; vif.IN = 4'b0001; step();
    vif.IN = 4'b0010; step();
    vif.IN = 4'd0; step();
    model_vote(4'b0001);
    read_all("single");

    // Seven non-one-hot ballots.
    do_clear();
    for (int n = 0; n < 7; n++) vote(pats[n % 4], 1);
    read_all("invalid");

    // Long hold plus a re-Ballot while armed.
    do_clear();
    vif.Ballot = 1'b1; step();
    vif.Ballot = 1'b0; step();
    vif.Ballot = 1'b1; step();
    vif.Ballot = 1'b0; vif.IN = 4'b0001;
    repeat (20) step();
    vif.IN = 4'd0; step();
    model_vote(4'b0001);
    show_total("hold20_tot");

    // 5/1/3/2 split, winner c1.
    do_clear();
    repeat (5) vote(4'b0001, 1);
    repeat (1) vote(4'b0010, 2);
    repeat (3) vote(4'b0100, 1);
    repeat (2) vote(4'b1000, 3);
    show_total("split_tot");
    read_all("split");

    // Power dip while CLOSED retains counts.
    vif.Power = 1'b0; step();
    check("dip_out0", vif.out, 0);
    step();
    check("dip_out1", vif.out, 0);
    vif.Power = 1'b1; step();
    read_all("after_dip");

    // Clear from CLOSED reopens voting.
    do_clear();
    vote(4'b0100, 1);
    read_all("reopen");

    // Randomized: zero-wait periods and Total while armed keep the ballot pending.
    do_clear();
    for (int n = 0; n < 60; n++) begin
      sel = 4'($urandom_range(0, 15));
      vif.Ballot = 1'b1; step();
      vif.Ballot = 1'b0;
      if (sel == 4'd0 || $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) step();
        show_total($sformatf("rnd_pending_tot%0d", n));
        if ($urandom_range(0, 1) == 1) begin
          vif.Ballot = 1'b1; step();
          vif.Ballot = 1'b0;
        end
        if (sel == 4'd0) sel = 4'($urandom_range(1, 15));
      end
      vif.IN = sel;
      repeat ($urandom_range(1, 5)) step();
      vif.IN = 4'd0;
      model_vote(sel);
      if (n % 10 == 9) show_total($sformatf("rnd_tot%0d", n));
    end
    read_all("rand");

    // Saturation at 4095.
    do_clear();
    repeat (4097) vote(4'b1111, 1);
    show_total("sat_tot");
    read_all("sat");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
